ex_shift_issue: RTL and testbench
=================================

# ex_shift_issue

Two-register execute slice around the combinational RV32I shifter. It accepts decoded shift instructions (SLL/SRL/SRA, register or immediate form) from decode and resolves rs1/rs2 through forwarding. It drives the shifter's `in`/`shamt`/`type` from an issue register (S1) and captures the shifter result into a result register (S2) for the memory stage. Valid/ready handshakes run on both sides, with stall back-pressure and synchronous flush.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- One clock; reset is asynchronous and active-low.
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  block accepts this cycle.
- dec_funct3  in  3  instruction funct3.
- dec_funct7_b5  in  1  instr[30].
- dec_is_imm  in  1  1 = SLLI/SRLI/SRAI form.
- dec_imm  in  5  immediate shamt (instr[24:20]).
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices.
- dec_rs1_val, dec_rs2_val  in  32 each  register-file read data.
- mem_fwd_valid, mem_fwd_rd, mem_fwd_data  in  1/5/32  memory-stage writeback candidate.
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/5/32  writeback-stage candidate.
- flush  in  1  kill all in-flight instructions.
- sh_in  out  32  shifter operand (S1 rs1).
- sh_shamt  out  32  shift amount, zero-extended 5 bits.
- sh_type  out  3  000 SLL, 001 SRL, 010 SRA, 111 illegal.
- sh_out  in  32  shifter result.
- ex_valid  out  1  S2 holds a result.
- ex_ready  in  1  downstream accepts.
- ex_rd  out  5  destination.
- ex_result  out  32  registered result.
- ex_illegal  out  1  S2 instruction had an invalid funct3/funct7 combination.

## Operation
- Decode map:
  - funct3=001, b5=0 → SLL.
  - funct3=101, b5=0 → SRL.
  - funct3=101, b5=1 → SRA.
  - Any other combination → type 111 with illegal=1. The instruction still flows and its result is 0.
- shamt source: dec_imm if dec_is_imm, else rs2[4:0]. Bits [31:5] of sh_shamt are always 0.
- Operand resolution happens at acceptance, per source, in priority order:
  1. shifter result of S1 instruction (s1_valid and s1_rd match);
  2. ex_result (ex_valid and ex_rd match);
  3. mem_fwd (mem_fwd_valid and rd match);
  4. wb_fwd (wb_fwd_valid and rd match);
  5. register-file value.
- Index 0 never matches; x0 always reads the register-file value.
- rs2 forwarding is ignored for immediate form.
- S1 captures funct-derived type, resolved rs1, shamt, rd and illegal. The sh_* outputs are driven directly from S1 registers.
- S2 captures sh_out (forced 0 if illegal), rd and illegal.
- Handshake rules:
  - s2_free = !ex_valid | ex_ready.
  - s1_adv = s1_valid & s2_free.
  - dec_ready = !s1_valid | s2_free (combinational; must not depend on dec_valid).
  - S1 loads on dec_valid & dec_ready.
  - S1 clears on s1_adv without a new load.
  - S2 loads on s1_adv.
  - S2 clears on ex_ready with no s1_adv.
- Flush takes priority over everything:
  - Next cycle s1_valid=0 and ex_valid=0, including any decode accepted in the flush cycle.
  - Data registers are don't-care.
- Holding: while ex_valid & !ex_ready, ex_rd/ex_result/ex_illegal are stable and S1 holds.

## Timing
- Latency: accept at edge N. sh_* valid after edge N. ex_valid after edge N+1.
- Throughput: one instruction per cycle with ex_ready=1.
- Reset (async assert, sync-released by the system):
  - s1_valid=0, ex_valid=0.
  - sh_in, sh_shamt, ex_result all 0; sh_type=111; ex_rd=0; ex_illegal=0.
  - dec_ready=1 on the first cycle.
- Reset mid-operation discards all in-flight instructions; there is no partial output.
- Full condition: S1 and S2 valid with ex_ready=0 gives dec_ready=0.
- Simultaneous ex_ready with dec_valid while full: both advance in the same edge, no bubble.
- Back-to-back dependency (rd of older = rs1 of younger): served from the S1 shifter path, no stall.

## Test plan
- Reset then SLL via register: rs1=0x0000_0001, rs2=0xFFFF_FFE4 (shamt 4) → sh_shamt=4, sh_type=000; two cycles later ex_result=0x0000_0010, ex_valid=1.
- SRAI with imm=31, rs1=0x8000_0000 → 0xFFFF_FFFF. SRLI with the same operands → 0x0000_0001.
- Dependent chain over three back-to-back cycles:
  - x5=SLLI x1,1 (x1=3), then x6=SLLI x5,1, then x7=SRL x6,x5.
  - Expected results: 6, 12, 0 (shamt 6 → 12>>6=0).
  - Also check MEM-over-WB priority and that rd=0 is never forwarded.
- Back-pressure: hold ex_ready=0 for 3 cycles with a stream queued → dec_ready drops after 2 accepts; ex_result stable; release → order preserved, no loss or duplication.
- funct3=000 issued → ex_illegal=1, ex_result=0, sh_type=111.
- Flush with both stages full and dec_valid=1 → next cycle ex_valid=0 and s1 empty. Asserting rst_n=0 mid-stream gives immediate reset values.

Source files
------------

// File: rtl/ex_shift_issue.sv
// Two-stage execute slice wrapped around an external RV32I shifter.
// S1 (issue) drives the shifter operands; S2 (result) captures the shifter
// output for the memory stage. Operands are resolved through forwarding at
// acceptance time.
module ex_shift_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [2:0]  dec_funct3,
  input  logic        dec_funct7_b5,
  input  logic        dec_is_imm,
  input  logic [4:0]  dec_imm,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic [31:0] dec_rs1_val,
  input  logic [31:0] dec_rs2_val,
  input  logic        mem_fwd_valid,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_valid,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  input  logic        flush,
  output logic [31:0] sh_in,
  output logic [31:0] sh_shamt,
  output logic [2:0]  sh_type,
  input  logic [31:0] sh_out,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_result,
  output logic        ex_illegal
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] T_SLL = 3'b000;
  localparam logic [TYPE_W-1:0] T_SRL = 3'b001;
  localparam logic [TYPE_W-1:0] T_SRA = 3'b010;
  localparam logic [TYPE_W-1:0] T_ILL = 3'b111;

  // S1 issue register
  logic              s1_valid;
  logic [XLEN-1:0]   s1_in;
  logic [REG_W-1:0]  s1_shamt;
  logic [TYPE_W-1:0] s1_type;
  logic [REG_W-1:0]  s1_rd;
  logic              s1_illegal;

  // handshake and decode intermediates
  logic              s2_free;
  logic              s1_adv;
  logic              s1_load;
  logic [XLEN-1:0]   s1_result;
  logic [TYPE_W-1:0] dec_type;
  logic              dec_illegal;
  logic [XLEN-1:0]   rs1_res;
  logic [XLEN-1:0]   rs2_res;
  logic [REG_W-1:0]  dec_shamt;

  // Picks the youngest in-flight producer of idx; x0 always reads the register file.
  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_W-1:0] idx,
    input logic [XLEN-1:0]  rf_val,
    input logic             s1_v,
    input logic [REG_W-1:0] s1_r,
    input logic [XLEN-1:0]  s1_d,
    input logic             s2_v,
    input logic [REG_W-1:0] s2_r,
    input logic [XLEN-1:0]  s2_d,
    input logic             m_v,
    input logic [REG_W-1:0] m_r,
    input logic [XLEN-1:0]  m_d,
    input logic             w_v,
    input logic [REG_W-1:0] w_r,
    input logic [XLEN-1:0]  w_d
  );
    logic [XLEN-1:0] val;
    val = rf_val;
    if (idx != '0) begin
      if (s1_v && s1_r == idx)      val = s1_d;
      else if (s2_v && s2_r == idx) val = s2_d;
      else if (m_v && m_r == idx)   val = m_d;
      else if (w_v && w_r == idx)   val = w_d;
    end
    return val;
  endfunction

  // Pipeline handshake: S2 drains or refills each cycle, S1 follows S2.
  always_comb begin
    s2_free   = !ex_valid || ex_ready;
    s1_adv    = s1_valid && s2_free;
    dec_ready = !s1_valid || s2_free;
    s1_load   = dec_valid && dec_ready;
  end

  // Value the S1 instruction will retire with; illegal ops produce zero.
  always_comb begin
    s1_result = s1_illegal ? '0 : sh_out;
  end

  // Map funct3/funct7[5] onto the shifter operation code.
  always_comb begin
    dec_type    = T_ILL;
    dec_illegal = 1'b1;
    if (dec_funct3 == 3'b001 && !dec_funct7_b5) begin
      dec_type    = T_SLL;
      dec_illegal = 1'b0;
    end else if (dec_funct3 == 3'b101 && !dec_funct7_b5) begin
      dec_type    = T_SRL;
      dec_illegal = 1'b0;
    end else if (dec_funct3 == 3'b101 && dec_funct7_b5) begin
      dec_type    = T_SRA;
      dec_illegal = 1'b0;
    end
  end

  // Resolve both sources; immediate form takes its shift amount from the instruction.
  always_comb begin
    rs1_res = resolve(dec_rs1, dec_rs1_val, s1_valid, s1_rd, s1_result,
                      ex_valid, ex_rd, ex_result, mem_fwd_valid, mem_fwd_rd,
                      mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    rs2_res = resolve(dec_rs2, dec_rs2_val, s1_valid, s1_rd, s1_result,
                      ex_valid, ex_rd, ex_result, mem_fwd_valid, mem_fwd_rd,
                      mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    dec_shamt = dec_is_imm ? dec_imm : rs2_res[REG_W-1:0];
  end

  // S1 occupancy: flush wins, then load, then drain into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       s1_valid <= 1'b0;
    else if (flush)   s1_valid <= 1'b0;
    else if (s1_load) s1_valid <= 1'b1;
    else if (s1_adv)  s1_valid <= 1'b0;
  end

  // S1 payload captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in      <= '0;
      s1_shamt   <= '0;
      s1_type    <= T_ILL;
      s1_rd      <= '0;
      s1_illegal <= 1'b0;
    end else if (s1_load) begin
      s1_in      <= rs1_res;
      s1_shamt   <= dec_shamt;
      s1_type    <= dec_type;
      s1_rd      <= dec_rd;
      s1_illegal <= dec_illegal;
    end
  end

  // S2 occupancy: flush wins, then refill from S1, then consumption downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ex_valid <= 1'b0;
    else if (flush)    ex_valid <= 1'b0;
    else if (s1_adv)   ex_valid <= 1'b1;
    else if (ex_ready) ex_valid <= 1'b0;
  end

  // S2 payload; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd      <= '0;
      ex_result  <= '0;
      ex_illegal <= 1'b0;
    end else if (s1_adv) begin
      ex_rd      <= s1_rd;
      ex_result  <= s1_result;
      ex_illegal <= s1_illegal;
    end
  end

  // Shifter operands come straight from the issue register.
  always_comb begin
    sh_in    = s1_in;
    sh_shamt = {{(XLEN-REG_W){1'b0}}, s1_shamt};
    sh_type  = s1_type;
  end

endmodule

// File: tb/tb_ex_shift_issue.sv
// Self-checking bench for ex_shift_issue: directed vector table, hand-written
// hazard/back-pressure/flush/reset sequences, and randomized traffic against
// an in-order queue model of in-flight instructions.
module tb_ex_shift_issue;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_funct3;
  logic        dec_funct7_b5;
  logic        dec_is_imm;
  logic [4:0]  dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_rs1_val, dec_rs2_val;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic [31:0] sh_in, sh_shamt;
  logic [2:0]  sh_type;
  logic [31:0] sh_out;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_illegal;

  int total = 0;
  int bad   = 0;
  logic last_acc;

  ex_shift_issue dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_funct3(dec_funct3), .dec_funct7_b5(dec_funct7_b5),
    .dec_is_imm(dec_is_imm), .dec_imm(dec_imm),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_type(sh_type), .sh_out(sh_out),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external shifter; garbage on illegal codes so forcing to 0 is visible.
  always_comb begin
    case (sh_type)
      3'b000:  sh_out = sh_in << sh_shamt[4:0];
      3'b001:  sh_out = sh_in >> sh_shamt[4:0];
      3'b010:  sh_out = $signed(sh_in) >>> sh_shamt[4:0];
      default: sh_out = 32'hDEAD_BEEF;
    endcase
  end

  // Reference model: in-flight instructions, oldest first.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] op;
    logic [4:0]  shamt;
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] res;
    logic        in_s2;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [2:0]  f3;
    logic        b5;
    logic        is_imm;
    logic [4:0]  imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [2:0]  e_type;
    logic [4:0]  e_shamt;
    logic [31:0] e_res;
    logic        e_ill;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] m_type(input logic [2:0] f3, input logic b5);
    if (f3 == 3'd1 && !b5) return 3'd0;
    if (f3 == 3'd5 && !b5) return 3'd1;
    if (f3 == 3'd5 && b5)  return 3'd2;
    return 3'd7;
  endfunction

  // Architectural value of a register as seen by a newly decoded instruction.
  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == idx) return q[i].res;
    if (mem_fwd_valid && mem_fwd_rd == idx) return mem_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == idx) return wb_fwd_data;
    return rf;
  endfunction

  // One clock: check ready, advance model at posedge, check outputs at negedge.
  task automatic step();
    ent_t e;
    logic rdy;
    logic acc;
    logic [31:0] s2v;
    #1;
    rdy = !(q.size() == 2 && !ex_ready);
    chk("dec_ready", 32'(dec_ready), 32'(rdy));
    acc = dec_valid && rdy;
    last_acc = acc;
    if (acc) begin
      e.rd    = dec_rd;
      e.typ   = m_type(dec_funct3, dec_funct7_b5);
      e.ill   = (e.typ == 3'd7);
      e.op    = m_read(dec_rs1, dec_rs1_val);
      s2v     = m_read(dec_rs2, dec_rs2_val);
      e.shamt = dec_is_imm ? dec_imm : s2v[4:0];
      case (e.typ)
        3'd0:    e.res = e.op << e.shamt;
        3'd1:    e.res = e.op >> e.shamt;
        3'd2:    e.res = $signed(e.op) >>> e.shamt;
        default: e.res = 32'd0;
      endcase
      e.in_s2 = 1'b0;
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].in_s2 && ex_ready) void'(q.pop_front());
      if (q.size() > 0 && !q[0].in_s2) q[0].in_s2 = 1'b1;
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    chk("ex_valid", 32'(ex_valid), 32'(q.size() > 0 && q[0].in_s2));
    if (q.size() > 0 && q[0].in_s2) begin
      chk("ex_rd", 32'(ex_rd), 32'(q[0].rd));
      chk("ex_result", ex_result, q[0].res);
      chk("ex_illegal", 32'(ex_illegal), 32'(q[0].ill));
    end
    if (q.size() > 0 && !q[q.size()-1].in_s2) begin
      chk("sh_in", sh_in, q[q.size()-1].op);
      chk("sh_shamt", sh_shamt, 32'(q[q.size()-1].shamt));
      chk("sh_type", 32'(sh_type), 32'(q[q.size()-1].typ));
    end
  endtask

  task automatic set_dec(input logic v, input logic [2:0] f3, input logic b5, input logic im,
                         input logic [4:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2);
    dec_valid = v; dec_funct3 = f3; dec_funct7_b5 = b5; dec_is_imm = im; dec_imm = imm;
    dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd; dec_rs1_val = v1; dec_rs2_val = v2;
  endtask

  task automatic fwd_off();
    mem_fwd_valid = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_sh_in"}, sh_in, 32'd0);
    chk({tag, "_sh_shamt"}, sh_shamt, 32'd0);
    chk({tag, "_sh_type"}, 32'(sh_type), 32'd7);
    chk({tag, "_ex_result"}, ex_result, 32'd0);
    chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, "_ex_illegal"}, 32'(ex_illegal), 32'd0);
    chk({tag, "_dec_ready"}, 32'(dec_ready), 32'd1);
  endtask

  initial begin
    int sent;
    int acc_stall;

    // f3 b5 imm? imm  rs1val  rs2val  mv mrd md  wv wrd wd  type shamt result ill
    vecs[0]  = '{3'd1, 1'b0, 1'b0, 5'd0,  32'h0000_0001, 32'hFFFF_FFE4, 1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd0, 5'd4,  32'h0000_0010, 1'b0};
    vecs[1]  = '{3'd5, 1'b1, 1'b1, 5'd31, 32'h8000_0000, 32'h0,         1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd2, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{3'd5, 1'b0, 1'b1, 5'd31, 32'h8000_0000, 32'h0,         1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd1, 5'd31, 32'h0000_0001, 1'b0};
    vecs[3]  = '{3'd0, 1'b0, 1'b1, 5'd3,  32'h0000_1234, 32'h0,         1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd7, 5'd3,  32'h0000_0000, 1'b1};
    vecs[4]  = '{3'd1, 1'b0, 1'b1, 5'd0,  32'hA5A5_A5A5, 32'h0,         1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd0, 5'd0,  32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{3'd5, 1'b0, 1'b0, 5'd0,  32'hF000_0000, 32'h0000_001F, 1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd1, 5'd31, 32'h0000_0001, 1'b0};
    vecs[6]  = '{3'd1, 1'b1, 1'b0, 5'd0,  32'h0000_0001, 32'h0000_0002, 1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd7, 5'd2,  32'h0000_0000, 1'b1};
    vecs[7]  = '{3'd5, 1'b1, 1'b0, 5'd0,  32'h8000_0000, 32'h0000_0008, 1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 3'd2, 5'd8,  32'hFF80_0000, 1'b0};
    vecs[8]  = '{3'd1, 1'b0, 1'b1, 5'd4,  32'h0000_0001, 32'h0,         1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd10, 32'hBBBB, 3'd0, 5'd4, 32'h000A_AAA0, 1'b0};
    vecs[9]  = '{3'd1, 1'b0, 1'b1, 5'd4,  32'h0000_0001, 32'h0,         1'b0, 5'd0,  32'd0, 1'b1, 5'd10, 32'hBBBB, 3'd0, 5'd4,  32'h000B_BBB0, 1'b0};
    vecs[10] = '{3'd1, 1'b0, 1'b1, 5'd1,  32'h0000_0005, 32'h0,         1'b1, 5'd11, 32'd3, 1'b0, 5'd0,  32'd0, 3'd0, 5'd1,  32'h0000_000A, 1'b0};
    vecs[11] = '{3'd1, 1'b0, 1'b0, 5'd0,  32'h0000_0005, 32'h0,         1'b1, 5'd11, 32'd3, 1'b0, 5'd0,  32'd0, 3'd0, 5'd3,  32'h0000_0028, 1'b0};

    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    set_dec(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    fwd_off();
    #2 rst_n = 1'b0;
    #10 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors, each issued into an otherwise idle pipeline.
    foreach (vecs[i]) begin
      set_dec(1'b1, vecs[i].f3, vecs[i].b5, vecs[i].is_imm, vecs[i].imm, 5'd10, 5'd11, 5'd12,
              vecs[i].v1, vecs[i].v2);
      mem_fwd_valid = vecs[i].mv; mem_fwd_rd = vecs[i].mrd; mem_fwd_data = vecs[i].md;
      wb_fwd_valid = vecs[i].wv; wb_fwd_rd = vecs[i].wrd; wb_fwd_data = vecs[i].wd;
      step();
      chk("vec_sh_type", 32'(sh_type), 32'(vecs[i].e_type));
      chk("vec_sh_shamt", sh_shamt, 32'(vecs[i].e_shamt));
      dec_valid = 1'b0;
      fwd_off();
      step();
      chk("vec_ex_valid", 32'(ex_valid), 32'd1);
      chk("vec_ex_result", ex_result, vecs[i].e_res);
      chk("vec_ex_illegal", 32'(ex_illegal), 32'(vecs[i].e_ill));
    end
    step();

    // Dependent chain: x5=x1<<1, x6=x5<<1, x7=x6>>x5.
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd1, 5'd1, 5'd0, 5'd5, 32'd3, 32'd0);
    step();
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd1, 5'd5, 5'd0, 5'd6, 32'h111, 32'd0);
    step();
    chk("chain_x5", ex_result, 32'd6);
    set_dec(1'b1, 3'd5, 1'b0, 1'b0, 5'd0, 5'd6, 5'd5, 5'd7, 32'h222, 32'h333);
    step();
    chk("chain_x6", ex_result, 32'd12);
    chk("chain_shamt", sh_shamt, 32'd6);
    dec_valid = 1'b0;
    step();
    chk("chain_x7", ex_result, 32'd0);

    // rd=0 is never forwarded, from the pipeline or from mem/wb.
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd1, 5'd1, 5'd0, 5'd0, 32'd7, 32'd0);
    step();
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hCC;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hDD;
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0);
    step();
    chk("x0_prod", ex_result, 32'd14);
    dec_valid = 1'b0;
    fwd_off();
    step();
    chk("x0_read", ex_result, 32'd0);
    step();

    // Back-pressure: three stalled cycles with a queued stream, then release.
    sent = 0; acc_stall = 0;
    for (int c = 0; c < 20 && sent < 5; c++) begin
      ex_ready = (c >= 3);
      set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'(sent), 5'd20, 5'd0, 5'(10 + sent), 32'(sent + 1), 32'd0);
      step();
      if (last_acc) sent++;
      if (c < 3 && last_acc) acc_stall++;
      if (c == 1 || c == 2) chk("bp_hold", ex_result, 32'd1);
      if (c == 2) chk("bp_ready_low", 32'(dec_ready), 32'd0);
    end
    chk("bp_accepts", 32'(acc_stall), 32'd2);
    chk("bp_sent", 32'(sent), 32'd5);
    dec_valid = 1'b0; ex_ready = 1'b1;
    repeat (3) step();

    // Flush with both stages full and a decode accepted in the same cycle.
    ex_ready = 1'b0;
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd2, 5'd20, 5'd0, 5'd21, 32'd9, 32'd0);
    step();
    set_dec(1'b1, 3'd5, 1'b1, 1'b1, 5'd2, 5'd20, 5'd0, 5'd22, 32'd9, 32'd0);
    step();
    chk("flush_full", 32'(ex_valid), 32'd1);
    flush = 1'b1; ex_ready = 1'b1;
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd1, 5'd20, 5'd0, 5'd23, 32'd9, 32'd0);
    step();
    chk("flush_ex", 32'(ex_valid), 32'd0);
    flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b0;
    step();
    chk("flush_s1", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1;

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      dec_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       dec_funct3 = 3'd1;
        1, 2:    dec_funct3 = 3'd5;
        default: dec_funct3 = 3'($urandom_range(0, 7));
      endcase
      dec_funct7_b5 = 1'($urandom_range(0, 1));
      dec_is_imm    = 1'($urandom_range(0, 1));
      dec_imm       = 5'($urandom);
      dec_rs1       = 5'($urandom_range(0, 7));
      dec_rs2       = 5'($urandom_range(0, 7));
      dec_rd        = 5'($urandom_range(0, 7));
      dec_rs1_val   = $urandom;
      dec_rs2_val   = $urandom;
      mem_fwd_valid = 1'($urandom_range(0, 1));
      mem_fwd_rd    = 5'($urandom_range(0, 7));
      mem_fwd_data  = $urandom;
      wb_fwd_valid  = 1'($urandom_range(0, 1));
      wb_fwd_rd     = 5'($urandom_range(0, 7));
      wb_fwd_data   = $urandom;
      ex_ready      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    fwd_off();

    // Asynchronous reset with both stages occupied.
    ex_ready = 1'b0;
    set_dec(1'b1, 3'd1, 1'b0, 1'b1, 5'd3, 5'd20, 5'd0, 5'd4, 32'd5, 32'd0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    dec_valid = 1'b0;
    step();
    chk("midrst_after", 32'(ex_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
